// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, the program counter, instruction memory and ID.
// Valid/ready: a word enters the stage when iREN && ihit (pc_advance); it leaves R when valid_o && !stall.
interface fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      pcaddr;
    logic [31:0]      nxt_pc;
    logic             ihit;
    logic [31:0]      imemload;
    logic             stall;
    logic             flush;
    logic             iREN;
    logic [31:0]      iaddr;
    logic             pc_advance;
    logic [31:0]      instr_o;
    logic [31:0]      pc_o;
    logic [31:0]      npc_o;
    logic             valid_o;
    logic             halted;
    logic [CNT_W-1:0] fetch_cnt;
    logic [1:0]       fetch_state;

    modport slave (
        input  pcaddr, nxt_pc, ihit, imemload, stall, flush,
        output iREN, iaddr, pc_advance, instr_o, pc_o, npc_o, valid_o, halted,
               fetch_cnt, fetch_state
    );

    modport master (
        output pcaddr, nxt_pc, ihit, imemload, stall, flush,
        input  iREN, iaddr, pc_advance, instr_o, pc_o, npc_o, valid_o, halted,
               fetch_cnt, fetch_state
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: requests at pcaddr, captures into output register R backed by skid register S,
// discards wrong-path words after a flush and stops on a halt opcode.
module fetch_stage #(
    parameter logic [5:0] HALT_OPCODE = 6'h3F,
    parameter int         CNT_W       = 32
) (
    input logic          CLK,
    input logic          nRST,
    fetch_stage_if.slave fif
);
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        KILL   = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } slot_t;

    state_t           state, state_n;
    slot_t            r_q, r_n, s_q, s_n, tuple;
    logic [CNT_W-1:0] cnt_q;
    logic             load_r;
    logic             iren, acc, drain, r_free;

    assign tuple  = {fif.imemload, fif.pcaddr, fif.nxt_pc, 1'b1};
    assign iren   = ((state == FETCH) || (state == KILL)) && !s_q.valid;
    assign acc    = iren && fif.ihit;
    assign drain  = r_q.valid && !fif.stall;
    assign r_free = !r_q.valid || drain;

    always_comb begin
        state_n = state;
        r_n     = r_q;
        s_n     = s_q;
        load_r  = 1'b0;
        if (fif.flush) begin
            // A word accepted alongside the flush is wrong-path, but the PC still takes the redirect.
            r_n.valid = 1'b0;
            s_n.valid = 1'b0;
            state_n   = acc ? FETCH : KILL;
        end else begin
            case (state)
                FETCH: begin
                    if (s_q.valid && r_free) begin
                        r_n       = s_q;
                        s_n.valid = 1'b0;
                        load_r    = 1'b1;
                    end else if (acc && r_free) begin
                        r_n    = tuple;
                        load_r = 1'b1;
                    end else if (acc) begin
                        s_n = tuple;
                    end else if (drain) begin
                        r_n.valid = 1'b0;
                    end
                    if (load_r && (r_n.instr[31:26] == HALT_OPCODE)) state_n = HALTED;
                end
                KILL: begin
                    // The first word returned after a flush without ihit is the stale request.
                    if (acc) state_n = FETCH;
                    if (drain) r_n.valid = 1'b0;
                end
                HALTED: begin
                    if (drain) r_n.valid = 1'b0;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            r_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            r_q   <= r_n;
            s_q   <= s_n;
            if (load_r) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign fif.iREN        = iren;
    assign fif.iaddr       = fif.pcaddr;
    assign fif.pc_advance  = acc;
    assign fif.instr_o     = r_q.instr;
    assign fif.pc_o        = r_q.pc;
    assign fif.npc_o       = r_q.npc;
    assign fif.valid_o     = r_q.valid;
    assign fif.halted      = (state == HALTED);
    assign fif.fetch_cnt   = cnt_q;
    assign fif.fetch_state = state;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a random streaming phase, all words
// checked against an expected queue as ID consumes them.
module tb_fetch_stage;
    localparam int CNT_W = 32;
    localparam logic [1:0] ST_FETCH = 2'd0, ST_KILL = 2'd1, ST_HALTED = 2'd2;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    fetch_stage_if #(.CNT_W(CNT_W)) bus ();

    fetch_stage #(.HALT_OPCODE(6'h3F), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .fif (bus.slave)
    );

    logic [95:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] word, input logic hit,
                         input logic stl, input logic fl);
        bus.pcaddr   = pc;
        bus.nxt_pc   = pc + 32'd4;
        bus.imemload = word;
        bus.ihit     = hit;
        bus.stall    = stl;
        bus.flush    = fl;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back({word, pc, pc + 32'd4});
        exp_cnt++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {6'h02, pc[27:2]};
    endfunction

    // ID-side consumer: every word leaving R must match the head of the queue.
    always @(negedge CLK) begin
        if (nRST && bus.valid_o && !bus.stall && !bus.flush) begin
            if (exp_q.size() == 0) check("sb_extra", 96'(bus.valid_o), 96'd0);
            else check("sb_word", {bus.instr_o, bus.pc_o, bus.npc_o}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int adv_cnt;
        logic [31:0] pc;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_valid", 96'(bus.valid_o), 96'd0);
        check("rst_out", {bus.instr_o, bus.pc_o, bus.npc_o}, 96'd0);
        check("rst_halted", 96'(bus.halted), 96'd0);
        check("rst_cnt", 96'(bus.fetch_cnt), 96'd0);
        check("rst_state", 96'(bus.fetch_state), 96'(ST_FETCH));
        tick();
        nRST = 1'b1;
        tick();

        // Streaming
        for (int i = 0; i < 3; i++) begin
            drive(32'(4 * i), 32'(i + 1), 1'b1, 1'b0, 1'b0);
            push(32'(4 * i), 32'(i + 1));
            @(negedge CLK);
            check("str_adv", 96'(bus.pc_advance), 96'd1);
            check("str_iaddr", 96'(bus.iaddr), 96'(4 * i));
            if (i == 0) check("str_valid_pre", 96'(bus.valid_o), 96'd0);
            else check("str_pc", {bus.pc_o, bus.npc_o}, {32'(4 * (i - 1)), 32'(4 * i)});
            tick();
        end
        drive(32'd12, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check("str_cnt", 96'(bus.fetch_cnt), 96'd3);
        tick();
        @(negedge CLK);
        check("str_empty", 96'(bus.valid_o), 96'd0);

        // Skid
        adv_cnt = 0;
        tick();
        drive(32'h10, 32'h10, 1'b1, 1'b0, 1'b0);
        push(32'h10, 32'h10);
        @(negedge CLK);
        adv_cnt += int'(bus.pc_advance);
        tick();
        drive(32'h14, 32'h14, 1'b1, 1'b1, 1'b0);
        push(32'h14, 32'h14);
        @(negedge CLK);
        adv_cnt += int'(bus.pc_advance);
        tick();
        drive(32'h18, 32'h18, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        check("skid_iren", 96'(bus.iREN), 96'd0);
        check("skid_hold", 96'(bus.pc_o), 96'h10);
        adv_cnt += int'(bus.pc_advance);
        tick();
        drive(32'h18, 32'h18, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("skid_iren_drain", 96'(bus.iREN), 96'd0);
        adv_cnt += int'(bus.pc_advance);
        tick();
        drive(32'h18, 32'h18, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        check("skid_pc", {bus.pc_o, 31'd0, bus.valid_o}, {32'h14, 32'd1});
        adv_cnt += int'(bus.pc_advance);
        check("skid_adv_count", 96'(adv_cnt), 96'd2);
        tick();
        drive(32'h18, 32'h18, 1'b0, 1'b0, 1'b0);
        tick();

        // Flush with ihit
        drive(32'h20, 32'h20, 1'b1, 1'b0, 1'b0);
        push(32'h20, 32'h20);
        tick();
        drive(32'h24, 32'h24, 1'b1, 1'b1, 1'b1);
        exp_q.delete();
        @(negedge CLK);
        check("fl_adv", 96'(bus.pc_advance), 96'd1);
        tick();
        drive(32'h60, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check("fl_valid", 96'(bus.valid_o), 96'd0);
        check("fl_cnt", 96'(bus.fetch_cnt), 96'(exp_cnt));
        check("fl_state", 96'(bus.fetch_state), 96'(ST_FETCH));
        tick();

        // Flush without ihit
        drive(32'h30, 32'h30, 1'b1, 1'b0, 1'b0);
        push(32'h30, 32'h30);
        tick();
        drive(32'h34, 32'h34, 1'b0, 1'b0, 1'b1);
        exp_q.delete();
        @(negedge CLK);
        check("kl_adv0", 96'(bus.pc_advance), 96'd0);
        tick();
        drive(32'h40, 32'h40, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check("kl_state", 96'(bus.fetch_state), 96'(ST_KILL));
        check("kl_valid", 96'(bus.valid_o), 96'd0);
        tick();
        tick();
        drive(32'h40, 32'h40, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("kl_adv", 96'(bus.pc_advance), 96'd1);
        tick();
        drive(32'h44, 32'h44, 1'b1, 1'b0, 1'b0);
        push(32'h44, 32'h44);
        @(negedge CLK);
        check("kl_resume_state", 96'(bus.fetch_state), 96'(ST_FETCH));
        check("kl_discard", 96'(bus.valid_o), 96'd0);
        tick();
        drive(32'h48, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check("kl_deliver", 96'(bus.valid_o), 96'd1);
        check("kl_cnt", 96'(bus.fetch_cnt), 96'(exp_cnt));
        tick();

        // Halt
        drive(32'h50, 32'hFC00_0000, 1'b1, 1'b0, 1'b0);
        push(32'h50, 32'hFC00_0000);
        tick();
        drive(32'h54, 32'h54, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("ht_instr", 96'(bus.instr_o), 96'hFC00_0000);
        check("ht_halted", 96'(bus.halted), 96'd1);
        check("ht_state", 96'(bus.fetch_state), 96'(ST_HALTED));
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge CLK);
            check("ht_iren", 96'(bus.iREN), 96'd0);
            check("ht_adv", 96'(bus.pc_advance), 96'd0);
        end
        check("ht_hold", 96'(bus.halted), 96'd1);
        tick();
        drive(32'h80, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'h80, 32'h80, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("ht_clear", 96'(bus.halted), 96'd0);
        check("ht_kill", 96'(bus.fetch_state), 96'(ST_KILL));
        tick();
        drive(32'h84, 32'h84, 1'b1, 1'b0, 1'b0);
        push(32'h84, 32'h84);
        tick();
        drive(32'h88, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check("ht_resume", {bus.pc_o, 31'd0, bus.valid_o}, {32'h84, 32'd1});
        tick();

        // Random streaming with the bench acting as the program counter
        pc = 32'h1000;
        for (int i = 0; i < 80; i++) begin
            drive(pc, mem_word(pc), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
            @(negedge CLK);
            if (bus.pc_advance) begin
                push(pc, mem_word(pc));
                pc = pc + 32'd4;
            end
            tick();
        end
        drive(pc, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("rand_drain", 96'(exp_q.size()), 96'd0);
        check("rand_cnt", 96'(bus.fetch_cnt), 96'(exp_cnt));

        // Async reset with S full and stall held
        drive(32'h200, 32'h200, 1'b1, 1'b0, 1'b0);
        push(32'h200, 32'h200);
        tick();
        drive(32'h204, 32'h204, 1'b1, 1'b1, 1'b0);
        push(32'h204, 32'h204);
        tick();
        drive(32'h208, 32'h208, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        check("ar_iren", 96'(bus.iREN), 96'd0);
        tick();
        #2;
        nRST = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        check("ar_valid", 96'(bus.valid_o), 96'd0);
        check("ar_cnt", 96'(bus.fetch_cnt), 96'd0);
        check("ar_state", 96'(bus.fetch_state), 96'(ST_FETCH));
        check("ar_iren_back", 96'(bus.iREN), 96'd1);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        nRST = 1'b1;
        tick();
        check("final_queue", 96'(exp_q.size()), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
